mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the IF and MEM pipeline stages and the single 8-bit RAM port.
- Arbitrates word fetches from IF against 1/2/4-byte loads and stores from MEM, and sequences the bytes little-endian.
- Returns assembled data with a one-cycle done pulse.
- Is the source of the IF and MEM stall requests consumed by the stall bus.

Parameters:
ADDR_WIDTH, 32, width of all address ports
RAM_LATENCY, 1, cycles from ram_addr_o presented to matching ram_din_i valid (only 1 supported)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
if_req_i  input  1  IF fetch request, held until if_done_o
if_addr_i  input  32  fetch address
if_inst_o  output  32  fetched word, valid when if_done_o
if_done_o  output  1  one-cycle fetch-complete pulse
if_stall_req_o  output  1  IF stall request to stall bus
mem_req_i  input  1  MEM access request, held until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_addr_i  input  32  access base address
mem_wdata_i  input  32  store data, low bytes used
mem_len_i  input  3  byte count: 1, 2 or 4
mem_rdata_o  output  32  load data, zero-extended, valid when mem_done_o
mem_done_o  output  1  one-cycle access-complete pulse
mem_stall_req_o  output  1  MEM stall request to stall bus
ram_din_i  input  8  RAM read byte
ram_dout_o  output  8  RAM write byte
ram_addr_o  output  32  RAM byte address
ram_wr_o  output  1  1 = write, 0 = read

Behaviour:
- Reset state: IDLE. All outputs 0, counter 0, latched request cleared.
- Reset mid-transaction aborts the transfer at the next edge:
  - no further ram_wr_o=1 cycles;
  - no done pulse for the aborted request.
- States: IDLE, READ, WRITE.
- IDLE transitions:
  - No request accepted in a cycle where if_done_o or mem_done_o is high; the requester is still dropping its request.
  - Otherwise mem_req_i has priority over if_req_i.
  - On acceptance, latch addr, wdata, len (IF len = 4) and owner; counter = 0.
  - A load or fetch goes to READ; a store goes to WRITE.
- Illegal mem_len_i (0, 3, 5-7) is treated as 4.
- A transaction is never preempted. Requester input changes after acceptance are ignored.
- READ, N bytes, occupies N+1 cycles:
  - In cycle t, ram_addr_o = base+t for t < N, with ram_wr_o=0.
  - For t >= 1, capture ram_din_i into byte t-1 of the data register.
  - After cycle N: return to IDLE, with the owner's done pulsing in the first IDLE cycle.
  - Data output holds until the next transaction of that owner completes.
- WRITE, N bytes, occupies N cycles:
  - In cycle t, ram_addr_o = base+t, ram_dout_o = wdata[8t+7:8t], ram_wr_o=1.
  - Then IDLE with mem_done_o pulsing.
- ram_wr_o is 1 only in WRITE cycles.
- Latency from the request-accept edge to the done pulse: READ N+2 cycles, WRITE N+1 cycles.
- Loaded bytes above N are 0.
- Address arithmetic is 32-bit, wrapping at 0xFFFFFFFF to 0.
- Stall requests are combinational:
  - if_stall_req_o = if_req_i & ~if_done_o
  - mem_stall_req_o = mem_req_i & ~mem_done_o
- A fetch waiting behind a MEM access keeps if_stall_req_o high throughout.
- A request withdrawn mid-transaction still completes and pulses done; the requester ignores the pulse.

Test Plan:
- Fetch: if_req_i=1, addr 0x1000, RAM holds 13 05 00 00 -> bytes 0x1000..0x1003 presented on consecutive cycles; if_done_o pulses 6 cycles after the accept edge with if_inst_o=0x00000513; if_stall_req_o high until then.
- Store byte: mem_we_i=1, len 1, addr 0x20, wdata 0xDEADBEEF -> exactly one cycle ram_wr_o=1, addr 0x20, dout 0xEF; mem_done_o 2 cycles after accept.
- Halfword load: len 2, addr 0x41, RAM 0x41=0x34, 0x42=0x12 -> mem_rdata_o=0x00001234; no ram_wr_o.
- Simultaneous requests: if_req_i and mem_req_i (word store at 0x100) asserted in the same cycle -> store served first with 4 write cycles; fetch starts only after the mem_done_o cycle; if_stall_req_o high for the whole interval.
- Reset mid-write: word store, rst_in=1 during write cycle 2 -> ram_wr_o=0 from the next cycle; no mem_done_o; state IDLE; all outputs 0.
- Back-to-back fetches with addr 0xFFFFFFFE: bytes wrap to 0x0 and 0x1; done pulses not adjacent (one gap cycle); second fetch returns correct data.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller sitting between the IF and MEM
// pipeline stages and a single 8-bit synchronous RAM port.
//
// A word fetch from IF or a 1/2/4-byte load/store from MEM is accepted in
// IDLE (MEM wins ties) and then sequenced one byte per cycle, little-endian.
// Loads and fetches are assembled into a 32-bit word, zero-extended, and
// returned with a one-cycle done pulse for the owning requester. The module
// also drives the IF/MEM stall requests for the stall bus.
//
// Ports:
//   clk_in, rst_in                  clock, synchronous active-high reset
//   if_req_i / if_addr_i            fetch request (held until if_done_o)
//   if_inst_o / if_done_o           fetched word and its completion pulse
//   if_stall_req_o                  IF stall request (combinational)
//   mem_req_i / mem_we_i            access request, 1 = store
//   mem_addr_i / mem_wdata_i        base address, store data (low bytes)
//   mem_len_i                       byte count 1/2/4 (other codes -> 4)
//   mem_rdata_o / mem_done_o        load data and its completion pulse
//   mem_stall_req_o                 MEM stall request (combinational)
//   ram_din_i                       RAM read byte, valid one cycle after addr
//   ram_dout_o / ram_addr_o         RAM write byte and byte address
//   ram_wr_o                        RAM write strobe
module mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           if_inst_o,
  output logic                  if_done_o,
  output logic                  if_stall_req_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [2:0]            mem_len_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  mem_stall_req_o,
  input  logic [7:0]            ram_din_i,
  output logic [7:0]            ram_dout_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  // Read data for the address presented in cycle t arrives in cycle t+LAT.
  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [2:0]            len_q;
  logic                  owner_mem_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rbuf_q;
  logic [31:0]           rbuf_d;
  logic [31:0]           if_inst_q;
  logic [31:0]           mem_rdata_q;
  logic                  if_done_q;
  logic                  mem_done_q;
  logic [7:0]            ram_dout_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_wr_q;

  logic [2:0]            len_dec;
  logic [2:0]            cnt_nx;
  logic [2:0]            byte_idx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] acc_addr;

  assign len_dec  = (mem_len_i == 3'd1 || mem_len_i == 3'd2) ? mem_len_i : 3'd4;
  assign cnt_nx   = cnt_q + 3'd1;
  assign byte_idx = cnt_q - LAT;
  // A requester is still lowering its request during its done cycle, so
  // nothing is accepted while either done pulse is high.
  assign accept   = (mem_req_i | if_req_i) & ~if_done_q & ~mem_done_q;
  assign acc_addr = mem_req_i ? mem_addr_i : if_addr_i;

  // Read buffer with the byte arriving this cycle merged in.
  always_comb begin
    rbuf_d = rbuf_q;
    if (cnt_q >= LAT) begin
      case (byte_idx)
        3'd0:    rbuf_d[7:0]   = ram_din_i;
        3'd1:    rbuf_d[15:8]  = ram_din_i;
        3'd2:    rbuf_d[23:16] = ram_din_i;
        3'd3:    rbuf_d[31:24] = ram_din_i;
        default: rbuf_d        = rbuf_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_dout_q  <= 8'd0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q       <= 3'd0;
            owner_mem_q <= mem_req_i;
            len_q       <= mem_req_i ? len_dec : 3'd4;
            base_q      <= acc_addr;
            wdata_q     <= mem_wdata_i;
            rbuf_q      <= 32'd0;
            ram_addr_q  <= acc_addr;
            if (mem_req_i && mem_we_i) begin
              state_q    <= WRITE;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_wdata_i[7:0];
            end else begin
              state_q    <= READ;
              ram_wr_q   <= 1'b0;
              ram_dout_q <= 8'd0;
            end
          end
        end
        READ: begin
          rbuf_q <= rbuf_d;
          if (cnt_q == len_q) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            if (owner_mem_q) begin
              mem_rdata_q <= rbuf_d;
              mem_done_q  <= 1'b1;
            end else begin
              if_inst_q <= rbuf_d;
              if_done_q <= 1'b1;
            end
          end else begin
            cnt_q      <= cnt_nx;
            ram_addr_q <= base_q + ADDR_WIDTH'(cnt_nx);
          end
        end
        WRITE: begin
          if (cnt_nx == len_q) begin
            state_q    <= IDLE;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= 8'd0;
            mem_done_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_nx;
            ram_addr_q <= base_q + ADDR_WIDTH'(cnt_nx);
            ram_dout_q <= 8'(wdata_q >> {cnt_nx, 3'b000});
          end
        end
        default: begin
          state_q  <= IDLE;
          ram_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_inst_o       = if_inst_q;
  assign if_done_o       = if_done_q;
  assign mem_rdata_o     = mem_rdata_q;
  assign mem_done_o      = mem_done_q;
  assign ram_dout_o      = ram_dout_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_wr_o        = ram_wr_q;
  assign if_stall_req_o  = if_req_i & ~if_done_q;
  assign mem_stall_req_o = mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        if_done_o;
  logic        if_stall_req_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  mem_len_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        mem_stall_req_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] ram [0:65535];

  mem_ctrl #(.ADDR_WIDTH(32), .RAM_LATENCY(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
    .if_done_o(if_done_o), .if_stall_req_o(if_stall_req_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_len_i(mem_len_i), .mem_rdata_o(mem_rdata_o),
    .mem_done_o(mem_done_o), .mem_stall_req_o(mem_stall_req_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous read-only RAM model with one cycle of read latency; writes
  // are only counted.
  always @(posedge clk_in) begin
    ram_din_i <= ram[ram_addr_o[15:0]];
    if (ram_wr_o) wr_cnt <= wr_cnt + 1;
  end

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = 32'd0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = 32'd0;
    mem_wdata_i = 32'd0;
    mem_len_i   = 3'd0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({if_inst_o, mem_rdata_o, ram_addr_o} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h, want 0", if_inst_o, mem_rdata_o, ram_addr_o);
    end
    checks++;
    if ({if_done_o, mem_done_o, ram_wr_o, if_stall_req_o, mem_stall_req_o, ram_dout_o} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b %h, want all 0", if_done_o, mem_done_o,
               ram_wr_o, if_stall_req_o, mem_stall_req_o, ram_dout_o);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] exp_a;
    if_req_i  = 1'b1;
    if_addr_i = 32'h1000;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk_in);
      exp_a = 32'h1000 + 32'(t);
      checks++;
      if (ram_addr_o !== exp_a || ram_wr_o !== 1'b0 || if_stall_req_o !== 1'b1) begin
        errors++;
        $display("FAIL fetch_addr t=%0d: got addr %h wr %b stall %b, want %h 0 1",
                 t, ram_addr_o, ram_wr_o, if_stall_req_o, exp_a);
      end
    end
    @(negedge clk_in);
    checks++;
    if (if_done_o !== 1'b0 || if_stall_req_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_early: got done %b stall %b, want 0 1", if_done_o, if_stall_req_o);
    end
    @(negedge clk_in);
    checks++;
    if (if_done_o !== 1'b1 || if_inst_o !== 32'h00000513 || if_stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: got done %b inst %h stall %b, want 1 00000513 0",
               if_done_o, if_inst_o, if_stall_req_o);
    end
    if_req_i = 1'b0;
    @(negedge clk_in);
    checks++;
    if (if_done_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse: done %b, want 0", if_done_o);
    end
  endtask

  task automatic test_store_byte();
    int w0;
    w0 = wr_cnt;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 3'd1;
    mem_addr_i = 32'h20; mem_wdata_i = 32'hDEADBEEF;
    @(negedge clk_in);
    checks++;
    if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h20 || ram_dout_o !== 8'hEF) begin
      errors++;
      $display("FAIL sb_write: got wr %b addr %h dout %h, want 1 00000020 ef",
               ram_wr_o, ram_addr_o, ram_dout_o);
    end
    @(negedge clk_in);
    checks++;
    if (mem_done_o !== 1'b1 || ram_wr_o !== 1'b0 || mem_stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL sb_done: got done %b wr %b stall %b, want 1 0 0",
               mem_done_o, ram_wr_o, mem_stall_req_o);
    end
    idle_inputs();
    @(negedge clk_in);
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL sb_count: got %0d write cycles, want 1", wr_cnt - w0);
    end
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [2:0] len,
                           input int nbytes, input logic [31:0] exp);
    int w0;
    w0 = wr_cnt;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = len; mem_addr_i = addr;
    for (int t = 0; t < nbytes; t++) begin
      @(negedge clk_in);
      checks++;
      if (ram_addr_o !== addr + 32'(t) || mem_done_o !== 1'b0) begin
        errors++;
        $display("FAIL load_addr len=%0d t=%0d: got %h done %b, want %h 0",
                 len, t, ram_addr_o, mem_done_o, addr + 32'(t));
      end
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (mem_done_o !== 1'b1 || mem_rdata_o !== exp) begin
      errors++;
      $display("FAIL load_data len=%0d: got done %b data %h, want 1 %h",
               len, mem_done_o, mem_rdata_o, exp);
    end
    idle_inputs();
    @(negedge clk_in);
    checks++;
    if (wr_cnt != w0 || mem_rdata_o !== exp) begin
      errors++;
      $display("FAIL load_hold len=%0d: got writes %0d data %h, want 0 %h",
               len, wr_cnt - w0, mem_rdata_o, exp);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_b [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    int n;
    if_req_i = 1'b1; if_addr_i = 32'h2000;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 3'd4;
    mem_addr_i = 32'h100; mem_wdata_i = 32'h11223344;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk_in);
      checks++;
      if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h100 + 32'(t) || ram_dout_o !== exp_b[t] ||
          if_stall_req_o !== 1'b1) begin
        errors++;
        $display("FAIL sim_write t=%0d: got wr %b addr %h dout %h stall %b, want 1 %h %h 1",
                 t, ram_wr_o, ram_addr_o, ram_dout_o, if_stall_req_o, 32'h100 + 32'(t), exp_b[t]);
      end
    end
    @(negedge clk_in);
    checks++;
    if (mem_done_o !== 1'b1 || if_done_o !== 1'b0 || if_stall_req_o !== 1'b1 || ram_wr_o !== 1'b0) begin
      errors++;
      $display("FAIL sim_mdone: got mdone %b idone %b stall %b wr %b, want 1 0 1 0",
               mem_done_o, if_done_o, if_stall_req_o, ram_wr_o);
    end
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk_in);
    checks++;
    if (ram_addr_o !== 32'd0 || if_stall_req_o !== 1'b1) begin
      errors++;
      $display("FAIL sim_gap: got addr %h stall %b, want 00000000 1", ram_addr_o, if_stall_req_o);
    end
    @(negedge clk_in);
    checks++;
    if (ram_addr_o !== 32'h2000 || ram_wr_o !== 1'b0) begin
      errors++;
      $display("FAIL sim_fetch_start: got addr %h wr %b, want 00002000 0", ram_addr_o, ram_wr_o);
    end
    n = 0;
    while (if_done_o !== 1'b1 && n < 20) begin
      checks++;
      if (if_stall_req_o !== 1'b1) begin
        errors++;
        $display("FAIL sim_stall: got %b, want 1", if_stall_req_o);
      end
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n != 5 || if_inst_o !== 32'h00100093) begin
      errors++;
      $display("FAIL sim_fetch_done: got %0d cycles inst %h, want 5 00100093", n, if_inst_o);
    end
    idle_inputs();
    @(negedge clk_in);
  endtask

  task automatic test_reset_mid_write();
    int w0;
    w0 = wr_cnt;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 3'd4;
    mem_addr_i = 32'h300; mem_wdata_i = 32'hCAFEF00D;
    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h301 || ram_dout_o !== 8'hF0) begin
      errors++;
      $display("FAIL rst_w2: got wr %b addr %h dout %h, want 1 00000301 f0",
               ram_wr_o, ram_addr_o, ram_dout_o);
    end
    rst_in = 1'b1;
    idle_inputs();
    @(negedge clk_in);
    rst_in = 1'b0;
    checks++;
    if ({ram_wr_o, mem_done_o, if_done_o, ram_dout_o, ram_addr_o, mem_rdata_o, if_inst_o} !== 107'd0) begin
      errors++;
      $display("FAIL rst_outputs: got wr %b mdone %b idone %b dout %h addr %h rdata %h inst %h, want 0",
               ram_wr_o, mem_done_o, if_done_o, ram_dout_o, ram_addr_o, mem_rdata_o, if_inst_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      checks++;
      if (mem_done_o !== 1'b0 || ram_wr_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_after %0d: got done %b wr %b, want 0 0", i, mem_done_o, ram_wr_o);
      end
    end
    checks++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL rst_wcount: got %0d write cycles, want 2", wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    int n;
    if_req_i = 1'b1; if_addr_i = 32'hFFFFFFFE;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk_in);
      checks++;
      if (ram_addr_o !== exp_a[t]) begin
        errors++;
        $display("FAIL b2b_wrap t=%0d: got %h, want %h", t, ram_addr_o, exp_a[t]);
      end
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (if_done_o !== 1'b1 || if_inst_o !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_first: got done %b inst %h, want 1 12345678", if_done_o, if_inst_o);
    end
    if_addr_i = 32'h3000;
    @(negedge clk_in);
    checks++;
    if (if_done_o !== 1'b0 || if_stall_req_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: got done %b stall %b, want 0 1", if_done_o, if_stall_req_o);
    end
    n = 0;
    while (if_done_o !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n != 6 || if_inst_o !== 32'hDEADBEEF || mem_rdata_o !== 32'h55AA1234) begin
      errors++;
      $display("FAIL b2b_second: got %0d cycles inst %h rdata %h, want 6 deadbeef 55aa1234",
               n, if_inst_o, mem_rdata_o);
    end
    idle_inputs();
    @(negedge clk_in);
  endtask

  initial begin
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h0041] = 8'h34; ram[16'h0042] = 8'h12; ram[16'h0043] = 8'hAA; ram[16'h0044] = 8'h55;
    ram[16'h2000] = 8'h93; ram[16'h2001] = 8'h00; ram[16'h2002] = 8'h10; ram[16'h2003] = 8'h00;
    ram[16'hFFFE] = 8'h78; ram[16'hFFFF] = 8'h56; ram[16'h0000] = 8'h34; ram[16'h0001] = 8'h12;
    ram[16'h3000] = 8'hEF; ram[16'h3001] = 8'hBE; ram[16'h3002] = 8'hAD; ram[16'h3003] = 8'hDE;

    test_reset();
    test_fetch();
    test_store_byte();
    test_load(32'h41, 3'd2, 2, 32'h00001234);
    test_simultaneous();
    test_reset_mid_write();
    test_load(32'h41, 3'd1, 1, 32'h00000034);
    test_load(32'h41, 3'd3, 4, 32'h55AA1234);
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
